instr_prefetch_queue: RTL and testbench

- Fetch stage that sits directly upstream of the microcoded control unit and supplies its 16-bit `instr` word.
- Reads instruction bytes from the 8-bit memory path as a big-endian pair: high byte at the even address, low byte at the odd address.
- Assembles each 16-bit word and buffers it, with its PC, in a small FIFO.
- Presents the FIFO head to the control unit through a valid/ready handshake; a flush (taken jump/branch) restarts fetch at a new PC.

---
 rtl/instr_prefetch_queue.sv | 163 ++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches big-endian 16-bit words one byte at a
// time over an 8-bit memory path, queues them together with their PC, and
// presents the queue head to the control unit on a valid/ready handshake.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       r,
    output logic                       mem_req,
    output logic [15:0]                mem_addr,
    input  logic                       mem_ack,
    input  logic [7:0]                 mem_data,
    input  logic                       flush,
    input  logic [15:0]                flush_pc,
    output logic                       instr_valid,
    output logic [15:0]                instr,
    output logic [15:0]                instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [15:0]   fetch_pc, fetch_pc_next;
    logic [15:0]   mem_addr_next;
    logic [7:0]    hi_byte, hi_byte_next;

    logic [15:0]   buf_instr [DEPTH];
    logic [15:0]   buf_pc    [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CW-1:0] count, count_next;

    logic          ack_taken;
    logic          push;
    logic          pop;
    logic [CW:0]   occ_after;
    logic [15:0]   push_instr;

    logic          head_valid_next;
    logic [15:0]   head_instr_next;
    logic [15:0]   head_pc_next;

    assign mem_req    = (state == HI) || (state == LO);
    assign ack_taken  = mem_req & mem_ack;
    assign pop        = instr_valid & instr_ready;
    assign push_instr = {hi_byte, mem_data};
    assign level      = count;

    // Occupancy once the current LO word lands, used to decide whether to keep fetching.
    assign occ_after  = {1'b0, count} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop};

    // Fetch FSM next-state, address sequencing and push generation; flush overrides.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        mem_addr_next = mem_addr;
        hi_byte_next  = hi_byte;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if ((count < DEPTH_C) || pop) begin
                    state_next    = HI;
                    mem_addr_next = fetch_pc;
                end
            end
            HI: begin
                if (ack_taken) begin
                    hi_byte_next  = mem_data;
                    mem_addr_next = fetch_pc | 16'h0001;
                    state_next    = LO;
                end
            end
            LO: begin
                if (ack_taken) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc + 16'd2;
                    mem_addr_next = fetch_pc + 16'd2;
                    state_next    = (occ_after < DEPTH_W) ? HI : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            push          = 1'b0;
            state_next    = HI;
            fetch_pc_next = {flush_pc[15:1], 1'b0};
            mem_addr_next = {flush_pc[15:1], 1'b0};
        end
    end

    // Queue pointer/count update and selection of the next registered head entry.
    always_comb begin
        wr_ptr_next     = push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_next     = pop  ? rd_ptr + AW'(1) : rd_ptr;
        count_next      = count + CW'(push) - CW'(pop);
        head_valid_next = 1'b0;
        head_instr_next = 16'h0000;
        head_pc_next    = 16'h0000;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
        if (count_next != '0) begin
            head_valid_next = 1'b1;
            // The slot being written this cycle is not in the buffer yet, so forward it.
            if (push && (rd_ptr_next == wr_ptr)) begin
                head_instr_next = push_instr;
                head_pc_next    = fetch_pc;
            end else begin
                head_instr_next = buf_instr[rd_ptr_next];
                head_pc_next    = buf_pc[rd_ptr_next];
            end
        end
    end

    // Control and head registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!r) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC & 16'hFFFE;
            mem_addr    <= 16'h0000;
            hi_byte     <= 8'h00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instr_valid <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            mem_addr    <= mem_addr_next;
            hi_byte     <= hi_byte_next;
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            instr_valid <= head_valid_next;
            instr       <= head_instr_next;
            instr_pc    <= head_pc_next;
        end
    end

    // Queue storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (r && push) begin
            buf_instr[wr_ptr] <= push_instr;
            buf_pc[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a vector table for fill/pop, then
// hand sequences for wait states, flush, reset mid-fetch and PC wrap.
module tb_instr_prefetch_queue;

    typedef struct {
        logic        r;
        logic        flush;
        logic [15:0] fpc;
        logic        ack;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] instr;
        logic [15:0] ipc;
        logic [15:0] level;
    } vec_t;

    logic        clk = 1'b0;
    logic        r, flush, mem_ack, instr_ready;
    logic [15:0] flush_pc;
    logic        mem_req, instr_valid;
    logic [15:0] mem_addr, instr, instr_pc;
    logic [7:0]  mem_data;
    logic [2:0]  level;

    logic        r2, flush2, mem_ack2, instr_ready2;
    logic [15:0] flush_pc2;
    logic        mem_req2, instr_valid2;
    logic [15:0] mem_addr2, instr2, instr_pc2;
    logic [7:0]  mem_data2;
    logic [2:0]  level2;

    int passed = 0;
    int total  = 0;
    vec_t tbl [20];

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h12;
            16'h0001: return 8'h34;
            16'h0002: return 8'h56;
            16'h0003: return 8'h78;
            16'hFFFE: return 8'hAB;
            16'hFFFF: return 8'hCD;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [15:0] word_at(input logic [15:0] pc);
        return {mem_byte(pc), mem_byte(pc | 16'h0001)};
    endfunction

    assign mem_data  = mem_byte(mem_addr);
    assign mem_data2 = mem_byte(mem_addr2);

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .r(r), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .flush(flush), .flush_pc(flush_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .level(level)
    );

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .r(r2), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_ack2), .mem_data(mem_data2), .flush(flush2), .flush_pc(flush_pc2),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_ready(instr_ready2), .level(level2)
    );

    function automatic vec_t mk(input logic vr, vfl, input logic [15:0] vfpc,
                                input logic vack, vrdy, vreq, input logic [15:0] vaddr,
                                input logic vvalid, input logic [15:0] vinstr, vipc, vlevel);
        vec_t v;
        v.r = vr; v.flush = vfl; v.fpc = vfpc; v.ack = vack; v.rdy = vrdy;
        v.req = vreq; v.addr = vaddr; v.valid = vvalid; v.instr = vinstr;
        v.ipc = vipc; v.level = vlevel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [15:0] addr,
                           input logic valid, input logic [15:0] ins, ipc, lvl);
        chk({tag, " mem_req"}, {15'd0, mem_req}, {15'd0, req});
        if (req) chk({tag, " mem_addr"}, mem_addr, addr);
        chk({tag, " instr_valid"}, {15'd0, instr_valid}, {15'd0, valid});
        chk({tag, " instr"}, instr, ins);
        chk({tag, " instr_pc"}, instr_pc, ipc);
        chk({tag, " level"}, {13'd0, level}, lvl);
    endtask

    initial begin
        r = 1'b0; flush = 1'b0; flush_pc = 16'h0000; mem_ack = 1'b0; instr_ready = 1'b0;
        r2 = 1'b0; flush2 = 1'b0; flush_pc2 = 16'h0000; mem_ack2 = 1'b0; instr_ready2 = 1'b0;

        //            r  fl fpc  ack rdy req addr      v  instr     pc        lvl
        tbl[0]  = mk(0, 0, 16'h0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[1]  = mk(0, 0, 16'h0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[2]  = mk(1, 0, 16'h0, 1, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[3]  = mk(1, 0, 16'h0, 1, 0, 1, 16'h0001, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[4]  = mk(1, 0, 16'h0, 1, 0, 1, 16'h0002, 1, 16'h1234, 16'h0000, 16'd1);
        tbl[5]  = mk(1, 0, 16'h0, 1, 0, 1, 16'h0003, 1, 16'h1234, 16'h0000, 16'd1);
        tbl[6]  = mk(1, 0, 16'h0, 1, 0, 1, 16'h0004, 1, 16'h1234, 16'h0000, 16'd2);
        tbl[7]  = mk(1, 0, 16'h0, 1, 0, 1, 16'h0005, 1, 16'h1234, 16'h0000, 16'd2);
        tbl[8]  = mk(1, 0, 16'h0, 1, 0, 1, 16'h0006, 1, 16'h1234, 16'h0000, 16'd3);
        tbl[9]  = mk(1, 0, 16'h0, 1, 0, 1, 16'h0007, 1, 16'h1234, 16'h0000, 16'd3);
        tbl[10] = mk(1, 0, 16'h0, 1, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'd4);
        tbl[11] = mk(1, 0, 16'h0, 1, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'd4);
        tbl[12] = mk(1, 0, 16'h0, 1, 1, 1, 16'h0008, 1, 16'h5678, 16'h0002, 16'd3);
        tbl[13] = mk(1, 0, 16'h0, 1, 0, 1, 16'h0009, 1, 16'h5678, 16'h0002, 16'd3);
        tbl[14] = mk(1, 0, 16'h0, 1, 0, 0, 16'h0000, 1, 16'h5678, 16'h0002, 16'd4);
        tbl[15] = mk(1, 0, 16'h0, 0, 1, 1, 16'h000A, 1, 16'h5E5F, 16'h0004, 16'd3);
        tbl[16] = mk(1, 0, 16'h0, 0, 1, 1, 16'h000A, 1, 16'h5C5D, 16'h0006, 16'd2);
        tbl[17] = mk(1, 0, 16'h0, 0, 1, 1, 16'h000A, 1, 16'h5253, 16'h0008, 16'd1);
        tbl[18] = mk(1, 0, 16'h0, 0, 1, 1, 16'h000A, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[19] = mk(1, 0, 16'h0, 0, 1, 1, 16'h000A, 0, 16'h0000, 16'h0000, 16'd0);

        for (int i = 0; i < 20; i++) begin
            r = tbl[i].r; flush = tbl[i].flush; flush_pc = tbl[i].fpc;
            mem_ack = tbl[i].ack; instr_ready = tbl[i].rdy;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
                    tbl[i].instr, tbl[i].ipc, tbl[i].level);
        end

        // Three wait cycles before every byte ack; fetch continues at 0x000A.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < 3; w++) begin
                    mem_ack = 1'b0;
                    tick();
                    chk($sformatf("wait i%0d b%0d w%0d req", i, b, w), {15'd0, mem_req}, 16'd1);
                    chk($sformatf("wait i%0d b%0d w%0d addr", i, b, w), mem_addr,
                        16'h000A + 16'(2*i + b));
                    chk($sformatf("wait i%0d b%0d w%0d level", i, b, w), {13'd0, level}, 16'(i));
                end
                mem_ack = 1'b1;
                tick();
                chk($sformatf("ack i%0d b%0d level", i, b), {13'd0, level}, 16'(i + b));
            end
        end
        chk("wait head instr", instr, word_at(16'h000A));
        chk("wait head pc", instr_pc, 16'h000A);

        // Flush while in LO with an ack and a pop in the same cycle.
        mem_ack = 1'b1;
        tick();
        chk("pre-flush LO addr", mem_addr, 16'h0011);
        flush = 1'b1; flush_pc = 16'h0101; instr_ready = 1'b1;
        tick();
        flush = 1'b0; instr_ready = 1'b0;
        chk_all("flush", 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 16'd0);
        mem_ack = 1'b0;
        tick();
        chk_all("flush idle", 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 16'd0);
        mem_ack = 1'b1;
        tick();
        chk_all("flush hi", 1'b1, 16'h0101, 1'b0, 16'h0000, 16'h0000, 16'd0);
        tick();
        chk_all("flush push", 1'b1, 16'h0102, 1'b1, word_at(16'h0100), 16'h0100, 16'd1);

        // Back-to-back flushes.
        flush = 1'b1; flush_pc = 16'h0200;
        tick();
        chk_all("flushA", 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0000, 16'd0);
        flush_pc = 16'h0303;
        tick();
        flush = 1'b0;
        chk_all("flushB", 1'b1, 16'h0302, 1'b0, 16'h0000, 16'h0000, 16'd0);

        // Reset asserted in LO with one entry queued.
        tick();
        tick();
        chk_all("prerst push", 1'b1, 16'h0304, 1'b1, word_at(16'h0302), 16'h0302, 16'd1);
        tick();
        chk("prerst LO addr", mem_addr, 16'h0305);
        r = 1'b0; instr_ready = 1'b1; flush = 1'b1; flush_pc = 16'h0400;
        tick();
        flush = 1'b0; instr_ready = 1'b0;
        chk("rst mem_addr", mem_addr, 16'h0000);
        chk_all("rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'd0);
        r = 1'b1;
        tick();
        chk_all("rel0", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'd0);
        tick();
        chk_all("rel1", 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000, 16'd0);
        tick();
        chk_all("rel2", 1'b1, 16'h0002, 1'b1, 16'h1234, 16'h0000, 16'd1);

        // Second instance: RESET_PC at the top of the address space.
        r2 = 1'b1; mem_ack2 = 1'b1;
        tick();
        chk("wrap req0", {15'd0, mem_req2}, 16'd1);
        chk("wrap addr0", mem_addr2, 16'hFFFE);
        tick();
        chk("wrap addr1", mem_addr2, 16'hFFFF);
        chk("wrap valid1", {15'd0, instr_valid2}, 16'd0);
        tick();
        chk("wrap valid", {15'd0, instr_valid2}, 16'd1);
        chk("wrap instr", instr2, 16'hABCD);
        chk("wrap pc", instr_pc2, 16'hFFFE);
        chk("wrap next addr", mem_addr2, 16'h0000);
        chk("wrap next req", {15'd0, mem_req2}, 16'd1);
        chk("wrap level", {13'd0, level2}, 16'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
